// File: rtl/delay_pulse_gen.sv
// delay_pulse_gen: after a start request, waits delay_val cycles, then drives
// a registered pulse of pulse_len cycles (0 counts as 1) and strobes done.
// Ports: clk, rst_n (async, active-low), ena (freezes state when low), start,
//   delay_val[WIDTH], pulse_len[PW] -> pulse_out, busy, done, remaining[WIDTH].
// Optional macro DELAY_PULSE_RETRIGGER_EN: start in WAIT/PULSE restarts the
//   delay from the current inputs; without it start only acts in IDLE.
module delay_pulse_gen #(
    parameter int WIDTH = 8,
    parameter int PW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic [WIDTH-1:0] delay_val,
    input  logic [PW-1:0]    pulse_len,
    output logic             pulse_out,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] remaining
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_PULSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [WIDTH-1:0] W_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0]    P_ONE = {{(PW-1){1'b0}}, 1'b1};

    logic [1:0]       state;
    logic [WIDTH-1:0] cnt;
    logic [PW-1:0]    pcnt;
    logic [PW-1:0]    pcnt_init;
    logic             retrig;

    // pcnt holds cycles left after the current pulse cycle, so P maps to P-1
    // and a zero length is clamped to a single-cycle pulse.
    always_comb begin
        pcnt_init = '0;
        if (pulse_len != '0) begin
            pcnt_init = pulse_len - P_ONE;
        end
    end

`ifdef DELAY_PULSE_RETRIGGER_EN
    assign retrig = start && ((state == S_WAIT) || (state == S_PULSE));
`else
    assign retrig = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            pcnt      <= '0;
            pulse_out <= 1'b0;
            done      <= 1'b0;
        end else if (ena) begin
            if (retrig) begin
                // Aborted run: restart the delay, drop the pulse, no done.
                cnt       <= delay_val;
                pcnt      <= pcnt_init;
                pulse_out <= 1'b0;
                done      <= 1'b0;
                state     <= S_WAIT;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        done <= 1'b0;
                        if (start) begin
                            cnt   <= delay_val;
                            pcnt  <= pcnt_init;
                            state <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (cnt == '0) begin
                            pulse_out <= 1'b1;
                            state     <= S_PULSE;
                        end else begin
                            cnt <= cnt - W_ONE;
                        end
                    end
                    S_PULSE: begin
                        if (pcnt == '0) begin
                            pulse_out <= 1'b0;
                            done      <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            pcnt <= pcnt - P_ONE;
                        end
                    end
                    S_DONE: begin
                        done  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy      = (state != S_IDLE);
    assign remaining = (state == S_WAIT) ? cnt : '0;

endmodule

// File: tb/tb_delay_pulse_gen.sv
// tb_delay_pulse_gen: directed bench for delay_pulse_gen.
// Observes outputs 1 time unit after each rising edge of clk.
module tb_delay_pulse_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       start;
    logic [7:0] delay_val;
    logic [3:0] pulse_len;
    logic       pulse_out;
    logic       busy;
    logic       done;
    logic [7:0] remaining;

    int errors = 0;
    int checks = 0;

    delay_pulse_gen #(.WIDTH(8), .PW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .start     (start),
        .delay_val (delay_val),
        .pulse_len (pulse_len),
        .pulse_out (pulse_out),
        .busy      (busy),
        .done      (done),
        .remaining (remaining)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic p, input logic b,
                        input logic d, input logic [7:0] r);
        chk({tag, ".pulse"}, {31'd0, pulse_out}, {31'd0, p});
        chk({tag, ".busy"}, {31'd0, busy}, {31'd0, b});
        chk({tag, ".done"}, {31'd0, done}, {31'd0, d});
        chk({tag, ".rem"}, {24'd0, remaining}, {24'd0, r});
    endtask

    task automatic tchk(input string tag, input logic p, input logic b,
                        input logic d, input logic [7:0] r);
        tick();
        chk4(tag, p, b, d, r);
    endtask

    initial begin
        rst_n = 1'b0;
        ena = 1'b0;
        start = 1'b0;
        delay_val = 8'd0;
        pulse_len = 4'd0;
        tick();
        tick();
        chk4("reset", 1'b0, 1'b0, 1'b0, 8'd0);
        rst_n = 1'b1;
        ena = 1'b1;
        tchk("idle", 1'b0, 1'b0, 1'b0, 8'd0);

        // D=3 P=2; inputs changed after start must not matter
        delay_val = 8'd3;
        pulse_len = 4'd2;
        start = 1'b1;
        tchk("t1.k0", 1'b0, 1'b1, 1'b0, 8'd3);
        start = 1'b0;
        delay_val = 8'd9;
        pulse_len = 4'd7;
        tchk("t1.k1", 1'b0, 1'b1, 1'b0, 8'd2);
        tchk("t1.k2", 1'b0, 1'b1, 1'b0, 8'd1);
        tchk("t1.k3", 1'b0, 1'b1, 1'b0, 8'd0);
        tchk("t1.k4", 1'b1, 1'b1, 1'b0, 8'd0);
        tchk("t1.k5", 1'b1, 1'b1, 1'b0, 8'd0);
        tchk("t1.k6", 1'b0, 1'b1, 1'b1, 8'd0);
        tchk("t1.k7", 1'b0, 1'b0, 1'b0, 8'd0);

        // D=0 P=0: minimum latency, single-cycle pulse
        delay_val = 8'd0;
        pulse_len = 4'd0;
        start = 1'b1;
        tchk("t2.k0", 1'b0, 1'b1, 1'b0, 8'd0);
        start = 1'b0;
        tchk("t2.k1", 1'b1, 1'b1, 1'b0, 8'd0);
        tchk("t2.k2", 1'b0, 1'b1, 1'b1, 8'd0);
        tchk("t2.k3", 1'b0, 1'b0, 1'b0, 8'd0);

        // D=5 P=1 with a 4-cycle ena freeze at remaining=2
        delay_val = 8'd5;
        pulse_len = 4'd1;
        start = 1'b1;
        tchk("t3.k0", 1'b0, 1'b1, 1'b0, 8'd5);
        start = 1'b0;
        tchk("t3.k1", 1'b0, 1'b1, 1'b0, 8'd4);
        tchk("t3.k2", 1'b0, 1'b1, 1'b0, 8'd3);
        tchk("t3.k3", 1'b0, 1'b1, 1'b0, 8'd2);
        ena = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tchk("t3.hold", 1'b0, 1'b1, 1'b0, 8'd2);
        end
        ena = 1'b1;
        start = 1'b0;
        tchk("t3.r1", 1'b0, 1'b1, 1'b0, 8'd1);
        tchk("t3.r0", 1'b0, 1'b1, 1'b0, 8'd0);
        tchk("t3.pul", 1'b1, 1'b1, 1'b0, 8'd0);
        // freeze with done asserted: it must hold
        tchk("t3.dn", 1'b0, 1'b1, 1'b1, 8'd0);
        ena = 1'b0;
        tchk("t3.dnh", 1'b0, 1'b1, 1'b1, 8'd0);
        ena = 1'b1;
        tchk("t3.idle", 1'b0, 1'b0, 1'b0, 8'd0);

        // D=10: async reset in mid-WAIT aborts immediately
        delay_val = 8'd10;
        pulse_len = 4'd1;
        start = 1'b1;
        tchk("t4.k0", 1'b0, 1'b1, 1'b0, 8'd10);
        start = 1'b0;
        tchk("t4.k1", 1'b0, 1'b1, 1'b0, 8'd9);
        tchk("t4.k2", 1'b0, 1'b1, 1'b0, 8'd8);
        tchk("t4.k3", 1'b0, 1'b1, 1'b0, 8'd7);
        tchk("t4.k4", 1'b0, 1'b1, 1'b0, 8'd6);
        #2;
        rst_n = 1'b0;
        #1;
        chk4("t4.async", 1'b0, 1'b0, 1'b0, 8'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tchk("t4.quiet", 1'b0, 1'b0, 1'b0, 8'd0);
        end

        // second start at edge k+2
        delay_val = 8'd3;
        pulse_len = 4'd1;
        start = 1'b1;
        tchk("t5.k0", 1'b0, 1'b1, 1'b0, 8'd3);
        start = 1'b0;
        tchk("t5.k1", 1'b0, 1'b1, 1'b0, 8'd2);
        start = 1'b1;
`ifdef DELAY_PULSE_RETRIGGER_EN
        tchk("t5.k2", 1'b0, 1'b1, 1'b0, 8'd3);
        start = 1'b0;
        tchk("t5.k3", 1'b0, 1'b1, 1'b0, 8'd2);
        tchk("t5.k4", 1'b0, 1'b1, 1'b0, 8'd1);
        tchk("t5.k5", 1'b0, 1'b1, 1'b0, 8'd0);
        tchk("t5.k6", 1'b1, 1'b1, 1'b0, 8'd0);
        tchk("t5.k7", 1'b0, 1'b1, 1'b1, 8'd0);
        tchk("t5.k8", 1'b0, 1'b0, 1'b0, 8'd0);
`else
        tchk("t5.k2", 1'b0, 1'b1, 1'b0, 8'd1);
        start = 1'b0;
        tchk("t5.k3", 1'b0, 1'b1, 1'b0, 8'd0);
        tchk("t5.k4", 1'b1, 1'b1, 1'b0, 8'd0);
        tchk("t5.k5", 1'b0, 1'b1, 1'b1, 8'd0);
        tchk("t5.k6", 1'b0, 1'b0, 1'b0, 8'd0);
`endif

        // start held high, D=1 P=1
        delay_val = 8'd1;
        pulse_len = 4'd1;
        start = 1'b1;
`ifdef DELAY_PULSE_RETRIGGER_EN
        for (int i = 0; i < 6; i++) begin
            tchk("t6.rearm", 1'b0, 1'b1, 1'b0, 8'd1);
        end
        start = 1'b0;
        tchk("t6.w0", 1'b0, 1'b1, 1'b0, 8'd0);
        tchk("t6.pul", 1'b1, 1'b1, 1'b0, 8'd0);
        tchk("t6.dn", 1'b0, 1'b1, 1'b1, 8'd0);
        tchk("t6.end", 1'b0, 1'b0, 1'b0, 8'd0);
`else
        for (int i = 0; i < 3; i++) begin
            tchk("t6.w1", 1'b0, 1'b1, 1'b0, 8'd1);
            tchk("t6.w0", 1'b0, 1'b1, 1'b0, 8'd0);
            tchk("t6.pul", 1'b1, 1'b1, 1'b0, 8'd0);
            tchk("t6.dn", 1'b0, 1'b1, 1'b1, 8'd0);
            tchk("t6.gap", 1'b0, 1'b0, 1'b0, 8'd0);
        end
        start = 1'b0;
        tchk("t6.end", 1'b0, 1'b0, 1'b0, 8'd0);
`endif

        // D=255 P=3: full-range delay without wrap
        delay_val = 8'd255;
        pulse_len = 4'd3;
        start = 1'b1;
        tchk("t7.k0", 1'b0, 1'b1, 1'b0, 8'd255);
        start = 1'b0;
        tchk("t7.k1", 1'b0, 1'b1, 1'b0, 8'd254);
        for (int i = 0; i < 253; i++) begin
            tick();
        end
        chk4("t7.r1", 1'b0, 1'b1, 1'b0, 8'd1);
        tchk("t7.r0", 1'b0, 1'b1, 1'b0, 8'd0);
        tchk("t7.p1", 1'b1, 1'b1, 1'b0, 8'd0);
        tchk("t7.p2", 1'b1, 1'b1, 1'b0, 8'd0);
        tchk("t7.p3", 1'b1, 1'b1, 1'b0, 8'd0);
        tchk("t7.dn", 1'b0, 1'b1, 1'b1, 8'd0);
        tchk("t7.end", 1'b0, 1'b0, 1'b0, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
